// File: rtl/cmp_ctrl_pkg.sv
// Shared definitions for the compare-mask loader and its serial shifter.
// Optional feature macro: CMP_MASK_PARITY_EN (adds one even-parity bit per frame).
package cmp_ctrl_pkg;

  localparam int MASK_W_DEF = 17;
  localparam int RUN_W_DEF  = 16;

`ifdef CMP_MASK_PARITY_EN
  localparam int PARITY_BITS = 1;
`else
  localparam int PARITY_BITS = 0;
`endif

  // Serial frame length for the default mask width.
  localparam int FRAME_W_DEF = MASK_W_DEF + PARITY_BITS;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

endpackage

// File: rtl/cmp_mask_shifter.sv
// Serial mask shifter: shift register, bit counter, pending-frame flag and,
// when CMP_MASK_PARITY_EN is defined, the even-parity check on completed frames.
//
// Handshake (SDI/SVALID/SREADY): a bit moves on a rising edge where svalid_i
// and sready_o are both high; svalid_i while sready_o is low is ignored and
// the sender keeps presenting the same bit.
module cmp_mask_shifter
  import cmp_ctrl_pkg::*;
#(
  parameter int MASK_W  = MASK_W_DEF,
  parameter int FRAME_W = FRAME_W_DEF
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              sdi_i,
  input  logic              svalid_i,
  input  logic              commit_i,
  output logic              sready_o,
  output logic [MASK_W-1:0] shadow_o,
  output logic              pend_o,
  output logic              perr_o
);

  localparam int CNT_W = $clog2(FRAME_W + 1);

  logic [FRAME_W-1:0] frame_q, frame_d;
  logic [CNT_W-1:0]   bitcnt_q, bitcnt_d;
  logic               pend_q, pend_d;
  logic               perr_q, perr_d;
  logic               xfer;
  logic               last_bit;

  assign xfer     = svalid_i && !pend_q;
  assign last_bit = (bitcnt_q == CNT_W'(FRAME_W - 1));

  // Next-state for shifting, frame completion and pending-flag handoff.
  always_comb begin
    frame_d  = frame_q;
    bitcnt_d = bitcnt_q;
    pend_d   = pend_q;
    perr_d   = 1'b0;
    if (commit_i) begin
      pend_d = 1'b0;
    end
    if (xfer) begin
      frame_d = {frame_q[FRAME_W-2:0], sdi_i};
      if (last_bit) begin
        bitcnt_d = '0;
`ifdef CMP_MASK_PARITY_EN
        // Odd total parity: drop the frame and flag it instead of pending it.
        if (^frame_d) begin
          perr_d = 1'b1;
        end else begin
          pend_d = 1'b1;
        end
`else
        pend_d = 1'b1;
`endif
      end else begin
        bitcnt_d = bitcnt_q + CNT_W'(1);
      end
    end
  end

  // Shifter state registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      frame_q  <= '0;
      bitcnt_q <= '0;
      pend_q   <= 1'b0;
      perr_q   <= 1'b0;
    end else begin
      frame_q  <= frame_d;
      bitcnt_q <= bitcnt_d;
      pend_q   <= pend_d;
      perr_q   <= perr_d;
    end
  end

  // Not ready during reset so no bit is accepted into a state being cleared.
  assign sready_o = !pend_q && !rst_i;
  // The mask occupies the top MASK_W bits; a parity bit, if any, sits below it.
  assign shadow_o = frame_q[FRAME_W-1 -: MASK_W];
  assign pend_o   = pend_q;
  assign perr_o   = perr_q;

endmodule

// File: rtl/cmp_mask_loader.sv
// Compare-mask loader: accepts a serial mask, commits it to C only while the
// counter is idle, and sequences the downstream count enable P_0.
// Optional feature macro: CMP_MASK_PARITY_EN (parity-checked frames, PERR pulse).
module cmp_mask_loader
  import cmp_ctrl_pkg::*;
#(
  parameter int MASK_W = MASK_W_DEF,
  parameter int RUN_W  = RUN_W_DEF
) (
  input  logic              CK,
  input  logic              RST,
  input  logic              SDI,
  input  logic              SVALID,
  output logic              SREADY,
  input  logic              START,
  input  logic              STOP,
  input  logic [RUN_W-1:0]  RUN_LEN,
  output logic [MASK_W-1:0] C,
  output logic              P_0,
  output logic              BUSY,
  output logic              LOAD_DONE,
  output logic              PERR,
  output state_e            dbg_state_o
);

  localparam int FRAME_W = MASK_W + PARITY_BITS;

  state_e             state_q, state_d;
  logic [RUN_W-1:0]   remaining_q, remaining_d;
  logic [MASK_W-1:0]  c_q, c_d;
  logic               load_done_q, load_done_d;
  logic [MASK_W-1:0]  shadow;
  logic               pend;
  logic               commit;

  cmp_mask_shifter #(
    .MASK_W  (MASK_W),
    .FRAME_W (FRAME_W)
  ) u_shifter (
    .clk_i    (CK),
    .rst_i    (RST),
    .sdi_i    (SDI),
    .svalid_i (SVALID),
    .commit_i (commit),
    .sready_o (SREADY),
    .shadow_o (shadow),
    .pend_o   (pend),
    .perr_o   (PERR)
  );

  // A pending mask is only moved to C while no run is in progress.
  assign commit = pend && (state_q == IDLE);

  // FSM next state and run-length bookkeeping; remaining==0 in RUN means free-run.
  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    case (state_q)
      IDLE: begin
        if (START && !STOP) begin
          state_d     = RUN;
          remaining_d = RUN_LEN;
        end
      end
      RUN: begin
        if (STOP) begin
          state_d     = IDLE;
          remaining_d = '0;
        end else if (remaining_q == RUN_W'(1)) begin
          state_d     = IDLE;
          remaining_d = '0;
        end else if (remaining_q != '0) begin
          remaining_d = remaining_q - RUN_W'(1);
        end
      end
      default: begin
        state_d     = IDLE;
        remaining_d = '0;
      end
    endcase
  end

  // Commit path: new mask and its completion pulse land together.
  always_comb begin
    c_d         = commit ? shadow : c_q;
    load_done_d = commit;
  end

  // FSM and run counter registers.
  always_ff @(posedge CK) begin
    if (RST) begin
      state_q     <= IDLE;
      remaining_q <= '0;
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
    end
  end

  // Output mask and load-done registers.
  always_ff @(posedge CK) begin
    if (RST) begin
      c_q         <= '0;
      load_done_q <= 1'b0;
    end else begin
      c_q         <= c_d;
      load_done_q <= load_done_d;
    end
  end

  assign C           = c_q;
  assign P_0         = (state_q == RUN);
  assign BUSY        = (state_q == RUN);
  assign LOAD_DONE   = load_done_q;
  assign dbg_state_o = state_q;

endmodule
